event_counter_bank: RTL and testbench
=====================================

# event_counter_bank

Parametrised multi-channel event profiler: counts NUM_CH independent event inputs, each configurable as rising-edge or level counting, with saturating or wrapping counters and sticky overflow flags. All counters are captured atomically into a shadow bank on a snapshot pulse, and the shadow bank is read back through an indexed, registered read port. It replaces fixed-function per-cache counters in the profiling units and connects to the CPU's cache, branch and stall strobes and to the profiler's register interface.

## Interface
- NUM_CH, 8, number of event channels (1..32)
- CNT_W, 32, counter width in bits (8..64)
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to 0
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  counting enable; low = counters hold, no clear
- clear  in  1  synchronous clear pulse for all counters and overflow flags
- event_in  in  NUM_CH  raw event strobes, one per channel
- mode  in  NUM_CH  per-channel mode: 0 = EDGE, 1 = LEVEL
- snap  in  1  copy all live counters to the shadow bank
- rd_en  in  1  read request
- rd_sel  in  $clog2(NUM_CH)+1  channel index to read
- rd_data  out  CNT_W  shadow counter value of the selected channel
- rd_valid  out  1  rd_data valid strobe
- overflow  out  NUM_CH  sticky per-channel overflow flags (live)

## Operation
- Reset: live counters, shadow bank, edge registers, overflow, rd_data and rd_valid all 0.
- Edge register prev[i] <= event_in[i] every cycle, regardless of enable or clear.
- Increment condition inc[i] = enable & (mode[i] ? event_in[i] : event_in[i] & ~prev[i]).
- EDGE mode counts once per assertion, however long the assertion lasts. LEVEL mode counts every cycle the input is high.
- Priority per channel: clear > inc > hold.
- Overflow:
  - When inc occurs with the counter at all-ones, overflow[i] is set (sticky).
  - With SATURATE=1 the counter stays at all-ones. With SATURATE=0 it wraps to 0.
  - Only clear or rst resets overflow.
- Snapshot: on a snap cycle, the shadow bank captures the live counter values as they were before that cycle's update.
  - If snap and clear occur in the same cycle, the shadow bank receives the pre-clear values.
- Read: when rd_en is high, rd_data <= shadow[rd_sel] on the next edge and rd_valid <= 1.
  - If rd_sel >= NUM_CH, rd_data <= 0 and rd_valid is still 1.
  - rd_data holds its last value while rd_en is low. rd_valid is a single-cycle pulse per request.
- A mode change takes effect on the same cycle. A mode change from LEVEL to EDGE on a held-high input does not count, because prev is already 1.
- While enable is low, prev keeps tracking event_in. Raising enable during a held-high EDGE input therefore produces no count.

## Timing
- An event sampled at edge N appears in the live counter after edge N. It is visible in the shadow bank after a snap at edge N+1 or later.
- Read latency is 1 cycle. Back-to-back reads are allowed with throughput of 1 per cycle.
- A snap and a read in the same cycle return the old shadow value. A read in the next cycle sees the new value.
- If rst asserts mid-operation, all state clears immediately and no partial snapshot is retained.
- overflow is a registered output, updated on the same edge as the counter.

## Structure
- Shared package profiler_pkg holds:
  - typedef enum logic {EV_EDGE=1'b0, EV_LEVEL=1'b1} ev_mode_t
  - localparam for the default CNT_W
- Sub-module event_counter_ch (parameters CNT_W, SATURATE) contains one channel's prev register, increment logic, counter and overflow flag.
  - The top level instantiates it with generate over NUM_CH and adds the shadow bank and the read mux.

## Test plan
- EDGE, CNT_W=32: ch0 high for 5 cycles, low 2, high 3; snap; read 0 -> rd_data=2, rd_valid one cycle after rd_en.
- LEVEL on the same stimulus on ch1 -> rd_data=8. With enable low during 2 of the high cycles -> rd_data=6.
- CNT_W=8, SATURATE=1, LEVEL high for 300 cycles -> counter=255, overflow[0]=1. Then clear -> counter 0, overflow 0.
- CNT_W=8, SATURATE=0, LEVEL high for 258 cycles -> counter=2, overflow=1.
- Count 7 on ch2, then assert snap and clear in the same cycle -> shadow[2]=7 and live counter=0. Read rd_sel=NUM_CH -> rd_data=0, rd_valid=1.
- Assert rst asynchronously mid-count, between edges -> all outputs 0 before the next edge. The event held high across reset release in EDGE mode counts 1.

Source files
------------

// File: rtl/profiler_pkg.sv
// rtl/profiler_pkg.sv - shared types and defaults for the event profiler
package profiler_pkg;

  typedef enum logic {EV_EDGE = 1'b0, EV_LEVEL = 1'b1} ev_mode_t;

  localparam int DEFAULT_CNT_W  = 32;
  localparam int DEFAULT_NUM_CH = 8;

endpackage

// File: rtl/event_counter_bank_if.sv
// rtl/event_counter_bank_if.sv - indexed shadow-bank read port
interface event_counter_bank_if
  import profiler_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int CNT_W  = DEFAULT_CNT_W
);

  localparam int SEL_W = $clog2(NUM_CH) + 1;

  logic             rd_en;
  logic [SEL_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;

  modport master (output rd_en, output rd_sel, input rd_data, input rd_valid);
  modport slave  (input rd_en, input rd_sel, output rd_data, output rd_valid);

endinterface

// File: rtl/event_counter_ch.sv
// rtl/event_counter_ch.sv - one event channel: edge detect, counter, sticky overflow
module event_counter_ch
  import profiler_pkg::*;
#(
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             event_in,
  input  ev_mode_t         mode,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic prev;
  logic inc;

  // prev follows the raw input unconditionally so enable/clear never create a fake edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= event_in;
  end

  // LEVEL counts every high cycle, EDGE only the first cycle of an assertion
  always_comb begin
    inc = 1'b0;
    if (enable) begin
      if (mode == EV_LEVEL) inc = event_in;
      else                  inc = event_in & ~prev;
    end
  end

  // counter and sticky overflow; clear wins over an increment in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc) begin
      if (&count) begin
        overflow <= 1'b1;
        if (SATURATE == 0) count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/event_counter_bank.sv
// rtl/event_counter_bank.sv - multi-channel event counters with snapshot shadow bank
module event_counter_bank
  import profiler_pkg::*;
#(
  parameter int NUM_CH   = DEFAULT_NUM_CH,
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter int SATURATE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [NUM_CH-1:0]    event_in,
  input  logic [NUM_CH-1:0]    mode,
  input  logic                 snap,
  event_counter_bank_if.slave  rd_bus,
  output logic [NUM_CH-1:0]    overflow
);

  localparam int SEL_W = $clog2(NUM_CH) + 1;

  logic [CNT_W-1:0] live   [NUM_CH];
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [CNT_W-1:0] rd_mux;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    event_counter_ch #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .clear    (clear),
      .event_in (event_in[i]),
      .mode     (ev_mode_t'(mode[i])),
      .count    (live[i]),
      .overflow (overflow[i])
    );
  end

  // shadow captures the pre-update live values, so a same-cycle clear cannot zero a snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= live[i];
    end
  end

  // read mux; out-of-range selects fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_bus.rd_sel == SEL_W'(i)) rd_mux = shadow[i];
    end
  end

  // registered read port: one-cycle latency, data held between requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bus.rd_data  <= '0;
      rd_bus.rd_valid <= 1'b0;
    end else begin
      rd_bus.rd_valid <= rd_bus.rd_en;
      if (rd_bus.rd_en) rd_bus.rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_event_counter_bank.sv
// tb/tb_event_counter_bank.sv - directed self-checking bench for event_counter_bank
module tb_event_counter_bank;

  logic       clk;
  logic       rst;
  logic       en;

  logic [7:0] ev, md, m_ov;
  logic       clr, snp;

  logic [1:0] s_ev, s_md, s_ov;
  logic       s_clr, s_snp;
  logic [1:0] w_ev, w_md, w_ov;
  logic       w_clr, w_snp;

  int n_total = 0;
  int n_bad   = 0;

  event_counter_bank_if #(.NUM_CH(8), .CNT_W(32)) m_bus ();
  event_counter_bank_if #(.NUM_CH(2), .CNT_W(8))  s_bus ();
  event_counter_bank_if #(.NUM_CH(2), .CNT_W(8))  w_bus ();

  event_counter_bank #(.NUM_CH(8), .CNT_W(32), .SATURATE(1)) u_main (
    .clk(clk), .rst(rst), .enable(en), .clear(clr), .event_in(ev), .mode(md),
    .snap(snp), .rd_bus(m_bus), .overflow(m_ov)
  );

  event_counter_bank #(.NUM_CH(2), .CNT_W(8), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .enable(en), .clear(s_clr), .event_in(s_ev), .mode(s_md),
    .snap(s_snp), .rd_bus(s_bus), .overflow(s_ov)
  );

  event_counter_bank #(.NUM_CH(2), .CNT_W(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .enable(en), .clear(w_clr), .event_in(w_ev), .mode(w_md),
    .snap(w_snp), .rd_bus(w_bus), .overflow(w_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap_main();
    snp = 1'b1;
    tick();
    snp = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int sel, input logic [31:0] exp);
    m_bus.rd_en  = 1'b1;
    m_bus.rd_sel = 4'(sel);
    tick();
    m_bus.rd_en = 1'b0;
    chk({tag, "_valid"}, 64'(m_bus.rd_valid), 64'd1);
    chk(tag, 64'(m_bus.rd_data), 64'(exp));
  endtask

  // 5 high, 2 low, 3 high, then low; enable dropped for cycles off_a..off_b
  task automatic run_pattern(input logic [7:0] mask, input int off_a, input int off_b);
    for (int c = 0; c < 10; c++) begin
      ev = (c < 5 || c >= 7) ? mask : 8'h00;
      en = !(c >= off_a && c <= off_b);
      tick();
    end
    ev = 8'h00;
    en = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0; en = 1'b1;
    ev = '0; md = '0; clr = 1'b0; snp = 1'b0;
    s_ev = '0; s_md = '0; s_clr = 1'b0; s_snp = 1'b0;
    w_ev = '0; w_md = '0; w_clr = 1'b0; w_snp = 1'b0;
    m_bus.rd_en = 1'b0; m_bus.rd_sel = '0;
    s_bus.rd_en = 1'b0; s_bus.rd_sel = '0;
    w_bus.rd_en = 1'b0; w_bus.rd_sel = '0;
    #2 rst = 1'b1;
    tick();
    tick();
    chk("rst_overflow", 64'(m_ov), 64'd0);
    chk("rst_rd_data",  64'(m_bus.rd_data), 64'd0);
    chk("rst_rd_valid", 64'(m_bus.rd_valid), 64'd0);
    rst = 1'b0;
    tick();

    // ch0 EDGE and ch1 LEVEL on the same waveform
    md = 8'b0000_0010;
    run_pattern(8'b0000_0011, -1, -1);
    snap_main();
    m_bus.rd_en = 1'b1;
    m_bus.rd_sel = 4'd0;
    #1;
    chk("rd_valid_latency", 64'(m_bus.rd_valid), 64'd0);
    tick();
    chk("edge_cnt_valid", 64'(m_bus.rd_valid), 64'd1);
    chk("edge_cnt", 64'(m_bus.rd_data), 64'd2);
    m_bus.rd_sel = 4'd1;
    tick();
    chk("level_cnt_b2b_valid", 64'(m_bus.rd_valid), 64'd1);
    chk("level_cnt", 64'(m_bus.rd_data), 64'd8);
    m_bus.rd_en = 1'b0;
    tick();
    chk("rd_valid_pulse", 64'(m_bus.rd_valid), 64'd0);
    chk("rd_data_hold", 64'(m_bus.rd_data), 64'd8);
    chk("no_overflow", 64'(m_ov), 64'd0);

    // same waveform, enable low for two high cycles
    clr = 1'b1; tick(); clr = 1'b0;
    run_pattern(8'b0000_0011, 1, 2);
    snap_main();
    rd_chk("edge_gated", 0, 32'd2);
    rd_chk("level_gated", 1, 32'd6);

    // snap and clear together keep the pre-clear value
    clr = 1'b1; tick(); clr = 1'b0;
    md[2] = 1'b1;
    ev[2] = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    ev[2] = 1'b0;
    tick();
    snp = 1'b1; clr = 1'b1;
    tick();
    snp = 1'b0; clr = 1'b0;
    rd_chk("snap_clear_shadow", 2, 32'd7);
    // snap plus read in one cycle returns the old shadow; next read sees the cleared live
    snp = 1'b1;
    rd_chk("snap_read_old", 2, 32'd7);
    snp = 1'b0;
    rd_chk("live_cleared", 2, 32'd0);
    rd_chk("sel_out_of_range", 8, 32'd0);

    // LEVEL->EDGE on held-high input, and enable rising on held-high EDGE input
    md[3] = 1'b1;
    ev[3] = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    md[3] = 1'b0;
    tick(); tick();
    ev[3] = 1'b0;
    en = 1'b0;
    ev[4] = 1'b1;
    tick(); tick();
    en = 1'b1;
    tick(); tick();
    ev[4] = 1'b0;
    tick();
    snap_main();
    rd_chk("mode_switch", 3, 32'd3);
    rd_chk("enable_on_held", 4, 32'd0);

    // 8-bit saturating, 300 level cycles
    s_md = 2'b01;
    s_ev = 2'b01;
    for (int c = 0; c < 300; c++) tick();
    s_ev = 2'b00;
    chk("sat_overflow", 64'(s_ov), 64'd1);
    s_snp = 1'b1; tick(); s_snp = 1'b0;
    s_bus.rd_en = 1'b1; s_bus.rd_sel = 2'd0; tick(); s_bus.rd_en = 1'b0;
    chk("sat_count", 64'(s_bus.rd_data), 64'd255);
    s_clr = 1'b1; tick(); s_clr = 1'b0;
    chk("sat_clear_overflow", 64'(s_ov), 64'd0);
    s_snp = 1'b1; tick(); s_snp = 1'b0;
    s_bus.rd_en = 1'b1; tick(); s_bus.rd_en = 1'b0;
    chk("sat_clear_count", 64'(s_bus.rd_data), 64'd0);

    // 8-bit wrapping, 258 level cycles
    w_md = 2'b01;
    w_ev = 2'b01;
    for (int c = 0; c < 258; c++) tick();
    w_ev = 2'b00;
    chk("wrap_overflow", 64'(w_ov), 64'd1);
    w_snp = 1'b1; tick(); w_snp = 1'b0;
    w_bus.rd_en = 1'b1; w_bus.rd_sel = 2'd0; tick(); w_bus.rd_en = 1'b0;
    chk("wrap_count", 64'(w_bus.rd_data), 64'd2);

    // asynchronous reset between edges, EDGE input held across release
    ev[0] = 1'b1;
    m_bus.rd_en = 1'b1;
    m_bus.rd_sel = 4'd3;
    tick();
    chk("pre_rst_data", 64'(m_bus.rd_data), 64'd3);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_data",  64'(m_bus.rd_data), 64'd0);
    chk("async_rst_valid", 64'(m_bus.rd_valid), 64'd0);
    chk("async_rst_wrap_ov", 64'(w_ov), 64'd0);
    chk("async_rst_wrap_data", 64'(w_bus.rd_data), 64'd0);
    m_bus.rd_en = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    ev[0] = 1'b0;
    tick();
    snap_main();
    rd_chk("held_across_reset", 0, 32'd1);
    rd_chk("reset_cleared_shadow", 3, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
